// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Brief    : Request/result bundle between the board front end and alu_seq.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op_sel;
    logic             load_sel;
    logic [WIDTH-1:0] din;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [3:0]       flags;

    modport master (
        output start, op_sel, load_sel, din,
        input  busy, done, y, reg_a, reg_b, flags
    );

    modport slave (
        input  start, op_sel, load_sel, din,
        output busy, done, y, reg_a, reg_b, flags
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Clocked ALU with A/B/Y registers, NZCV flags and serial shifter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    alu_seq_if.slave    bus
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    localparam logic [3:0] c_OP_ADD  = 4'h0;
    localparam logic [3:0] c_OP_SUB  = 4'h1;
    localparam logic [3:0] c_OP_SHL  = 4'h2;
    localparam logic [3:0] c_OP_SHR  = 4'h3;
    localparam logic [3:0] c_OP_CMP  = 4'h4;
    localparam logic [3:0] c_OP_AND  = 4'h5;
    localparam logic [3:0] c_OP_OR   = 4'h6;
    localparam logic [3:0] c_OP_XOR  = 4'h7;
    localparam logic [3:0] c_OP_NAND = 4'h8;
    localparam logic [3:0] c_OP_NOR  = 4'h9;
    localparam logic [3:0] c_OP_XNOR = 4'hA;
    localparam logic [3:0] c_OP_NOT  = 4'hB;
    localparam logic [3:0] c_OP_NEG  = 4'hC;
    localparam logic [3:0] c_OP_STO  = 4'hD;
    localparam logic [3:0] c_OP_SWP  = 4'hE;
    localparam logic [3:0] c_OP_LOAD = 4'hF;

    localparam logic [WIDTH-1:0]   c_MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   c_ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SHAMT_W-1:0] c_ONE_SH   = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]         c_FLAGS_RST = 4'b0100;

    logic [0:0]         r_state;
    logic               r_start_q;
    logic [SHAMT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_work;
    logic               r_shift_left;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_y;
    logic [3:0]         r_flags;
    logic               r_done;

    logic               w_accept;
    logic [SHAMT_W-1:0] w_amount;
    logic               w_go_shift;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_y_new;
    logic               w_c_new;
    logic               w_v_new;
    logic [WIDTH-1:0]   w_work_next;
    logic               w_shift_out;

    // Only a fresh rising edge seen while idle starts an operation.
    assign w_accept   = bus.start & ~r_start_q & (r_state == c_ST_IDLE);
    assign w_amount   = r_b[SHAMT_W-1:0];
    assign w_go_shift = ((bus.op_sel == c_OP_SHL) || (bus.op_sel == c_OP_SHR)) &&
                        (w_amount != {SHAMT_W{1'b0}});

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};

    assign w_work_next = r_shift_left ? {r_work[WIDTH-2:0], 1'b0}
                                      : {1'b0, r_work[WIDTH-1:1]};
    assign w_shift_out = r_shift_left ? r_work[WIDTH-1] : r_work[0];

    always_comb begin
        w_y_new = r_a;
        w_c_new = 1'b0;
        w_v_new = 1'b0;
        case (bus.op_sel)
            c_OP_ADD: begin
                w_y_new = w_sum[WIDTH-1:0];
                w_c_new = w_sum[WIDTH];
                w_v_new = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            c_OP_SUB: begin
                w_y_new = w_diff[WIDTH-1:0];
                w_c_new = w_diff[WIDTH];
                w_v_new = (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != r_a[WIDTH-1]);
            end
            // Zero-amount shifts complete immediately and pass A through.
            c_OP_SHL, c_OP_SHR: w_y_new = r_a;
            c_OP_CMP: begin
                w_y_new = (r_a == r_b) ? {WIDTH{1'b0}} :
                          (r_a >  r_b) ? c_ONE_W : {WIDTH{1'b1}};
                w_c_new = w_diff[WIDTH];
            end
            c_OP_AND:  w_y_new = r_a & r_b;
            c_OP_OR:   w_y_new = r_a | r_b;
            c_OP_XOR:  w_y_new = r_a ^ r_b;
            c_OP_NAND: w_y_new = ~(r_a & r_b);
            c_OP_NOR:  w_y_new = ~(r_a | r_b);
            c_OP_XNOR: w_y_new = ~(r_a ^ r_b);
            c_OP_NOT:  w_y_new = ~r_a;
            c_OP_NEG: begin
                w_y_new = {WIDTH{1'b0}} - r_a;
                w_c_new = (r_a != {WIDTH{1'b0}});
                w_v_new = (r_a == c_MSB_ONLY);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_start_q    <= 1'b0;
            r_count      <= {SHAMT_W{1'b0}};
            r_work       <= {WIDTH{1'b0}};
            r_shift_left <= 1'b0;
            r_a          <= {WIDTH{1'b0}};
            r_b          <= {WIDTH{1'b0}};
            r_y          <= {WIDTH{1'b0}};
            r_flags      <= c_FLAGS_RST;
            r_done       <= 1'b0;
        end else begin
            r_start_q <= bus.start;
            r_done    <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                if (w_accept) begin
                    if (w_go_shift) begin
                        r_state      <= c_ST_SHIFT;
                        r_work       <= r_a;
                        r_count      <= w_amount;
                        r_shift_left <= (bus.op_sel == c_OP_SHL);
                    end else begin
                        r_done <= 1'b1;
                        case (bus.op_sel)
                            c_OP_STO: r_a <= r_y;
                            c_OP_SWP: begin
                                r_a <= r_b;
                                r_b <= r_a;
                            end
                            c_OP_LOAD: begin
                                if (bus.load_sel) r_b <= bus.din;
                                else              r_a <= bus.din;
                            end
                            default: begin
                                r_y     <= w_y_new;
                                r_flags <= {w_y_new[WIDTH-1],
                                            (w_y_new == {WIDTH{1'b0}}),
                                            w_c_new, w_v_new};
                            end
                        endcase
                    end
                end
            end else begin
                r_work  <= w_work_next;
                r_count <= r_count - c_ONE_SH;
                if (r_count == c_ONE_SH) begin
                    r_state <= c_ST_IDLE;
                    r_y     <= w_work_next;
                    r_flags <= {w_work_next[WIDTH-1],
                                (w_work_next == {WIDTH{1'b0}}),
                                w_shift_out, 1'b0};
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (r_state == c_ST_SHIFT);
    assign bus.done  = r_done;
    assign bus.y     = r_y;
    assign bus.reg_a = r_a;
    assign bus.reg_b = r_b;
    assign bus.flags = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic rst16_n;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n),   .bus(bus8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst16_n), .bus(bus16));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue8(input logic [3:0] op, input logic ls, input logic [7:0] d);
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sel = op; bus8.load_sel = ls; bus8.din = d;
        @(negedge clk);
        bus8.start = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] op, input logic ls, input logic [15:0] d);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op_sel = op; bus16.load_sel = ls; bus16.din = d;
        @(negedge clk);
        bus16.start = 1'b0;
    endtask

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        issue8(4'hF, 1'b0, a);
        issue8(4'hF, 1'b1, b);
    endtask

    // Loads operands, runs one op, waits (bounded) for done, checks Y, flags and A.
    task automatic run_vec(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] y, input logic [3:0] fl);
        int n;
        load8(a, b);
        issue8(op, 1'b0, 8'h00);
        n = 0;
        while (bus8.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"},  bus8.done,  1);
        check({tag, "_y"},     bus8.y,     y);
        check({tag, "_flags"}, bus8.flags, fl);
        check({tag, "_a"},     bus8.reg_a, a);
    endtask

    initial begin
        int n;
        int dones;
        bus8.start = 1'b0;  bus8.op_sel = 4'h0;  bus8.load_sel = 1'b0;  bus8.din = 8'h00;
        bus16.start = 1'b0; bus16.op_sel = 4'h0; bus16.load_sel = 1'b0; bus16.din = 16'h0;
        rst_n = 1'b0; rst16_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_y",     bus8.y,     0);
        check("rst_a",     bus8.reg_a, 0);
        check("rst_b",     bus8.reg_b, 0);
        check("rst_flags", bus8.flags, 4'b0100);
        check("rst_busy",  bus8.busy,  0);
        check("rst_done",  bus8.done,  0);
        rst_n = 1'b1; rst16_n = 1'b1;

        // First transaction with exact done timing
        issue8(4'hF, 1'b0, 8'h7F);
        check("load_a", bus8.reg_a, 8'h7F);
        check("load_a_flags", bus8.flags, 4'b0100);
        issue8(4'hF, 1'b1, 8'h01);
        check("load_b", bus8.reg_b, 8'h01);
        issue8(4'h0, 1'b0, 8'h00);
        check("add_done",  bus8.done,  1);
        check("add_y",     bus8.y,     8'h80);
        check("add_flags", bus8.flags, 4'b1001);
        @(negedge clk);
        check("add_done_clr", bus8.done, 0);

        run_vec("add_c",   4'h0, 8'hF0, 8'h20, 8'h10, 4'b0010);
        run_vec("add_z",   4'h0, 8'hFF, 8'h01, 8'h00, 4'b0110);
        run_vec("sub",     4'h1, 8'h03, 8'h05, 8'hFE, 4'b1010);
        run_vec("cmp_lt",  4'h4, 8'h03, 8'h05, 8'hFF, 4'b1010);
        run_vec("sub_v",   4'h1, 8'h80, 8'h01, 8'h7F, 4'b0001);
        run_vec("cmp_gt",  4'h4, 8'h80, 8'h01, 8'h01, 4'b0000);
        run_vec("cmp_eq",  4'h4, 8'h5A, 8'h5A, 8'h00, 4'b0100);
        run_vec("and",     4'h5, 8'hC5, 8'h3A, 8'h00, 4'b0100);
        run_vec("or",      4'h6, 8'hC5, 8'h3A, 8'hFF, 4'b1000);
        run_vec("xor",     4'h7, 8'hC6, 8'h3A, 8'hFC, 4'b1000);
        run_vec("nand",    4'h8, 8'hC5, 8'h3A, 8'hFF, 4'b1000);
        run_vec("nor",     4'h9, 8'hC5, 8'h3A, 8'h00, 4'b0100);
        run_vec("xnor",    4'hA, 8'hC6, 8'h3A, 8'h03, 4'b0000);
        run_vec("not",     4'hB, 8'hC5, 8'h3A, 8'h3A, 4'b0000);
        run_vec("neg1",    4'hC, 8'h01, 8'h00, 8'hFF, 4'b1010);
        run_vec("shr1",    4'h3, 8'h81, 8'h01, 8'h40, 4'b0010);

        // SHL by 3 with spurious start edges while busy
        load8(8'h81, 8'h03);
        issue8(4'h2, 1'b0, 8'h00);
        check("shl_busy0", bus8.busy, 1);
        check("shl_done0", bus8.done, 0);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("shl_busy1", bus8.busy, 1);
        check("shl_done1", bus8.done, 0);
        @(negedge clk);
        check("shl_busy2", bus8.busy, 1);
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        check("shl_busy3", bus8.busy,  0);
        check("shl_done3", bus8.done,  1);
        check("shl_y",     bus8.y,     8'h08);
        check("shl_flags", bus8.flags, 4'b0000);
        @(negedge clk);
        check("shl_done4", bus8.done,  0);
        check("shl_busy4", bus8.busy,  0);
        check("shl_y4",    bus8.y,     8'h08);
        check("shl_a",     bus8.reg_a, 8'h81);

        // Zero-amount shift completes in one clock
        load8(8'h81, 8'h00);
        issue8(4'h3, 1'b0, 8'h00);
        check("shr0_busy",  bus8.busy,  0);
        check("shr0_done",  bus8.done,  1);
        check("shr0_y",     bus8.y,     8'h81);
        check("shr0_flags", bus8.flags, 4'b1000);

        // Held start yields exactly one operation
        dones = 0;
        @(negedge clk);
        bus8.start = 1'b1; bus8.op_sel = 4'h3;
        repeat (10) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
        end
        bus8.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus8.done === 1'b1) dones++;
        end
        check("held_start_dones", dones, 1);

        load8(8'h12, 8'h34);
        issue8(4'hE, 1'b0, 8'h00);
        check("swp_a",     bus8.reg_a, 8'h34);
        check("swp_b",     bus8.reg_b, 8'h12);
        check("swp_y",     bus8.y,     8'h81);
        check("swp_flags", bus8.flags, 4'b1000);
        check("swp_done",  bus8.done,  1);

        load8(8'h80, 8'h00);
        issue8(4'hC, 1'b0, 8'h00);
        check("neg_y",     bus8.y,     8'h80);
        check("neg_flags", bus8.flags, 4'b1011);
        issue8(4'hF, 1'b0, 8'h05);
        issue8(4'hD, 1'b0, 8'h00);
        check("sto_a",     bus8.reg_a, 8'h80);
        check("sto_y",     bus8.y,     8'h80);
        check("sto_flags", bus8.flags, 4'b1011);
        check("sto_done",  bus8.done,  1);

        // 16-bit instance: full-length shift, then reset mid-shift
        issue16(4'hF, 1'b0, 16'h8000);
        issue16(4'hF, 1'b1, 16'h000F);
        issue16(4'h3, 1'b0, 16'h0000);
        n = 0;
        while (bus16.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("w16_busy_cycles", n, 15);
        check("w16_done",  bus16.done,  1);
        check("w16_y",     bus16.y,     16'h0001);
        check("w16_flags", bus16.flags, 4'b0000);

        issue16(4'h3, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        check("w16_mid_busy", bus16.busy, 1);
        rst16_n = 1'b0;
        #1;
        check("w16_rst_y",     bus16.y,     0);
        check("w16_rst_a",     bus16.reg_a, 0);
        check("w16_rst_b",     bus16.reg_b, 0);
        check("w16_rst_busy",  bus16.busy,  0);
        check("w16_rst_done",  bus16.done,  0);
        check("w16_rst_flags", bus16.flags, 4'b0100);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus16.done === 1'b1) dones++;
        end
        rst16_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus16.done === 1'b1 || bus16.busy === 1'b1) dones++;
        end
        check("w16_no_done_after_rst", dones, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Clocked, parametrised successor to the lab ALU. It holds operand registers A and B and result register Y, with WIDTH generalised. It adds N/Z/C/V flags, a start/busy/done handshake, and multi-cycle barrel-free shifts by a variable amount. It also has a working swap and a load path selectable to A or B. It sits between the board switch/button debouncers and the LED/seven-seg display logic, and runs on the board clock instead of a button clock.

Parameters:
WIDTH, 8, datapath width of A, B, Y and din (>=4)
SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from B[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level request (debounced btnC); rising edge is detected internally
op_sel  input  4  operation code, sampled at accept
load_sel  input  1  LOAD destination: 0=A, 1=B, sampled at accept
din  input  WIDTH  load data (switches), sampled at accept
busy  output  1  high while a multi-cycle shift is in progress
done  output  1  one-cycle pulse when an operation completes
y  output  WIDTH  result register Y
reg_a  output  WIDTH  operand register A (LED display)
reg_b  output  WIDTH  operand register B (LED display)
flags  output  4  {N,Z,C,V}

Behaviour:
- Reset (async, rst_n=0): A=B=Y=0, flags=4'b0100 (Z=1), busy=0, done=0, start_q=0, state=IDLE, shift count=0. Deassertion is synchronous to clk through the normal flop path. Reset mid-shift aborts the shift; no done pulse.
- Edge detect: start_q<=start every cycle. accept = start & ~start_q & (state==IDLE). Edges while busy are dropped, not queued. Holding start high produces exactly one accept.
- FSM states:
  - IDLE --accept & op in {2,3} & amount!=0--> SHIFT.
  - SHIFT --count==1 at edge--> IDLE.
  - All other accepts complete in IDLE.
- Single-cycle ops: results written at the accept edge. done=1 for the following cycle only. Latency = 1 clk.
- Op map (A,B,Y unsigned unless noted):
  - 0 ADD: Y=A+B; C=carry out; V=signed overflow.
  - 1 SUB: Y=A-B; C=borrow (A<B); V=signed overflow.
  - 2 SHL, 3 SHR (logical): amount k=B[SHAMT_W-1:0].
    - k=0: Y=A, C=0, one-cycle completion.
    - k>0: at accept, work=A and count=k, busy=1. Each SHIFT edge shifts work by one and decrements count; C=last bit shifted out.
    - On the final edge Y=work (shifted k times), busy=0; done pulses next cycle.
    - Total latency k clocks to Y, done in cycle k+1. A is unchanged. V=0.
  - 4 CMP: Y=0 if A==B, 1 if A>B, all-ones if A<B; C=(A<B); V=0.
  - 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, A XNOR, B NOT(A): C=V=0.
  - C NEG: Y=-A (two's complement); C=(A!=0); V=(A==1<<(WIDTH-1)).
  - D STO: A<=Y.
  - E SWP: A<=B and B<=A in the same edge.
  - F LOAD: (load_sel ? B : A) <= din.
- For ops 0-C: Z=(Y_new==0), N=Y_new[WIDTH-1]. For ops D-F: Y and flags are unchanged; done still pulses.
- busy and done are never high together. done is registered and never combinational from start.
- Widths: internal add/sub use WIDTH+1 bits for carry/borrow; no truncation warnings permitted.

Test Plan:
- Reset, then LOAD A=0x7F (load_sel=0), LOAD B=0x01 (load_sel=1), ADD -> Y=0x80, flags N=1 Z=0 C=0 V=1, done one cycle after accept edge.
- A=0x03, B=0x05, SUB -> Y=0xFE, C=1, N=1, V=0. Then CMP -> Y=0xFF, C=1.
- A=0x81, B=0x03, SHL -> busy high 3 clocks, Y=0x08, C=0 (last bit out), done in cycle 4. Start pulses during busy are ignored (single done, Y unchanged).
- A=0x81, B=0x00, SHR -> completes in 1 clk, Y=0x81, busy never asserted. Start held high for 10 cycles -> exactly one done.
- A=0x12, B=0x34, SWP -> A=0x34, B=0x12, Y/flags unchanged. NEG with A=0x80 -> Y=0x80, V=1, C=1. STO -> A=Y.
- WIDTH=16 instance: A=0x8000, B=0x000F, SHR -> Y=0x0001 after 15 busy clocks. Assert rst_n low mid-shift -> all outputs at reset values immediately, no done.
